gate_sweep_ctrl: RTL and testbench



---
 rtl/gate_sweep_pkg.sv | 21 ++
 rtl/gate_sweep_ctrl_settle_timer.sv | 43 ++++
 rtl/gate_sweep_ctrl.sv | 140 ++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// Purpose: shared state encoding, limits and 2-input truth tables for the gate sweep controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    localparam int MAX_INPUTS = 8;

    // Bit k is the expected gate output when the input vector equals k.
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// Purpose: loadable down-counter that times how long each vector is held before checking.
// Latency: load takes effect on the next edge; value counts down one per dec cycle.
// Backpressure: none; dec at zero is ignored so the counter never wraps.
module settle_timer
    import gate_sweep_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: a load overrides any decrement in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Purpose: sweeps all 2**N_INPUTS input vectors of a gate, checks dut_y against TRUTH_TABLE; optional GATE_SWEEP_STOP_ON_FAIL_EN halts at the first mismatch.
// Latency: done rises 2**N_INPUTS*(SETTLE_CYCLES+1)+1 cycles after the edge that samples start.
// Backpressure: none; start is ignored while a sweep is in progress (SETTLE/CHECK).
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int                          N_INPUTS      = 2,
    parameter int                          SETTLE_CYCLES = 1,
    parameter logic [(1<<N_INPUTS)-1:0]    TRUTH_TABLE   = TT_AND2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [N_INPUTS-1:0] vec_out,
    input  logic                dut_y,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   err_count,
    output logic [N_INPUTS-1:0] first_fail
);

    localparam int                   NUM_VEC     = 1 << N_INPUTS;
    localparam logic [N_INPUTS-1:0]  LAST_VEC    = N_INPUTS'(NUM_VEC - 1);
    localparam logic [N_INPUTS-1:0]  VEC_ONE     = N_INPUTS'(1);
    localparam logic [N_INPUTS:0]    ERR_ONE     = (N_INPUTS+1)'(1);
    localparam logic [N_INPUTS:0]    ERR_MAX     = (N_INPUTS+1)'(NUM_VEC);
    localparam logic [3:0]           SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    sweep_state_t        state_q;
    logic [N_INPUTS-1:0] vec_q;
    logic [N_INPUTS:0]   err_q;
    logic [N_INPUTS-1:0] first_fail_q;
    logic                fail_seen_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;

    logic                exp_bit;
    logic                mismatch;
    logic                last_vec;
    logic                start_ok;
    logic                halt;
    logic                advance;
    logic                tmr_load;
    logic                tmr_dec;
    logic [3:0]          tmr_value;
    logic                tmr_zero;

    // Check-cycle decode; an X/Z on dut_y never equals the expected bit, so it counts as a mismatch.
    always_comb begin
        exp_bit  = TRUTH_TABLE[vec_q];
        mismatch = (dut_y === exp_bit) ? 1'b0 : 1'b1;
        last_vec = (vec_q == LAST_VEC);
        start_ok = start && ((state_q == IDLE) || (state_q == DONE));
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        halt     = (state_q == CHECK) && mismatch;
`else
        halt     = 1'b0;
`endif
        advance  = (state_q == CHECK) && !last_vec && !halt;
        tmr_load = start_ok || advance;
        tmr_dec  = (state_q == SETTLE) && !tmr_zero;
    end

    settle_timer #(
        .W (4)
    ) u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (SETTLE_LOAD),
        .dec      (tmr_dec),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    // Sweep FSM and registered status; busy/done/pass are taken from the current state so they trail it by one edge, except that a restart from DONE drops done/pass at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            err_q        <= '0;
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            busy_q <= (state_q == SETTLE) || (state_q == CHECK);
            done_q <= (state_q == DONE) && !start;
            pass_q <= (state_q == DONE) && !start && (err_q == '0);
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= SETTLE;
                        vec_q        <= '0;
                        err_q        <= '0;
                        first_fail_q <= '0;
                        fail_seen_q  <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (tmr_value == '0) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_q != ERR_MAX) begin
                            err_q <= err_q + ERR_ONE;
                        end
                        if (!fail_seen_q) begin
                            first_fail_q <= vec_q;
                            fail_seen_q  <= 1'b1;
                        end
                    end
                    // The last vector is detected before incrementing, so vec_q never wraps.
                    if (last_vec || halt) begin
                        state_q <= DONE;
                    end else begin
                        vec_q   <= vec_q + VEC_ONE;
                        state_q <= SETTLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign vec_out    = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Purpose: directed bench for gate_sweep_ctrl with a 2-input gate model (AND/OR/stuck-at-1) and a 3-input AND instance.
// Latency: checks done timing against 2**N*(SETTLE+1)+1 cycles after start.
// Backpressure: n/a.
module tb_gate_sweep_ctrl;
    import gate_sweep_pkg::*;

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       start3;
    logic [1:0] gate_sel;

    logic [1:0] vec;
    logic       y;
    logic       busy, done, pass;
    logic [2:0] err;
    logic [1:0] ff;

    logic [2:0] vec3;
    logic       y3;
    logic       busy3, done3, pass3;
    logic [3:0] err3;
    logic [2:0] ff3;

    int checks   = 0;
    int failures = 0;
    int cyc;

    always #5 clk = ~clk;

    // Gate under test: 0 = AND, 1 = OR, otherwise stuck-at-1.
    always_comb begin
        case (gate_sel)
            2'd0:    y = &vec;
            2'd1:    y = |vec;
            default: y = 1'b1;
        endcase
    end

    assign y3 = &vec3;

    gate_sweep_ctrl #(
        .N_INPUTS      (2),
        .SETTLE_CYCLES (1),
        .TRUTH_TABLE   (TT_AND2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .vec_out    (vec),
        .dut_y      (y),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err),
        .first_fail (ff)
    );

    gate_sweep_ctrl #(
        .N_INPUTS      (3),
        .SETTLE_CYCLES (3),
        .TRUTH_TABLE   (8'b1000_0000)
    ) dut3 (
        .clk        (clk),
        .reset      (reset),
        .start      (start3),
        .vec_out    (vec3),
        .dut_y      (y3),
        .busy       (busy3),
        .done       (done3),
        .pass       (pass3),
        .err_count  (err3),
        .first_fail (ff3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the edge that sampled start (cycle 0).
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts cycles until done is seen, bounded so a stuck DUT shows up as a latency failure.
    task automatic wait_done(input int from, output int n);
        n = from;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        start3   = 1'b0;
        gate_sel = 2'd0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_vec",   vec,  0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_pass",  pass, 0);
        chk("rst_err",   err,  0);
        chk("rst_ff",    ff,   0);
        chk("rst3_done", done3, 0);
        chk("rst3_err",  err3,  0);

        reset = 1'b0;
        @(negedge clk);

        // Known-good AND: each vector held two cycles, done at cycle 9
        pulse_start();
        chk("t1_vec_c0", vec, 0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("t1_vec_seq", vec, (c / 2 > 3) ? 3 : c / 2);
            if (c == 1) chk("t1_busy", busy, 1);
        end
        chk("t1_done_early", done, 0);
        wait_done(8, cyc);
        chk("t1_latency", cyc,  9);
        chk("t1_pass",    pass, 1);
        chk("t1_err",     err,  0);
        chk("t1_ff",      ff,   0);
        chk("t1_vec_end", vec,  3);
        chk("t1_busy_end", busy, 0);

        // OR gate against AND table; restart from DONE clears done immediately
        gate_sel = 2'd1;
        pulse_start();
        chk("t2_done_clr", done, 0);
        chk("t2_err_clr",  err,  0);
        wait_done(0, cyc);
        chk("t2_latency", cyc,  STOP ? 5 : 9);
        chk("t2_err",     err,  STOP ? 1 : 2);
        chk("t2_ff",      ff,   1);
        chk("t2_pass",    pass, 0);
        chk("t2_vec_end", vec,  STOP ? 1 : 3);

        // Stuck-at-1 output
        gate_sel = 2'd2;
        pulse_start();
        wait_done(0, cyc);
        chk("t3_latency", cyc,  STOP ? 3 : 9);
        chk("t3_err",     err,  STOP ? 1 : 3);
        chk("t3_ff",      ff,   0);
        chk("t3_pass",    pass, 0);
        chk("t3_vec_end", vec,  STOP ? 0 : 3);

        // start while busy at vector 1 is ignored
        gate_sel = 2'd0;
        pulse_start();
        repeat (2) @(negedge clk);
        chk("t4_vec_c2", vec, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_vec_c3",  vec,  1);
        chk("t4_busy_c3", busy, 1);
        wait_done(3, cyc);
        chk("t4_latency", cyc,  9);
        chk("t4_pass",    pass, 1);

        // Reset during CHECK of vector 2, with start asserted in the same cycle
        pulse_start();
        repeat (5) @(negedge clk);
        chk("t5_vec_c5",  vec,  2);
        chk("t5_busy_c5", busy, 1);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("t5_vec_rst",  vec,  0);
        chk("t5_busy_rst", busy, 0);
        chk("t5_err_rst",  err,  0);
        chk("t5_done_rst", done, 0);
        @(negedge clk);
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_vec",  vec,  0);
        pulse_start();
        wait_done(0, cyc);
        chk("t5_latency", cyc,  9);
        chk("t5_pass",    pass, 1);
        chk("t5_err",     err,  0);

        // 3-input AND, four cycles per vector, done at cycle 33
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_vec_c3", vec3, 0);
        @(negedge clk);
        chk("t6_vec_c4", vec3, 1);
        cyc = 4;
        while (!done3 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6_latency", cyc,   33);
        chk("t6_pass",    pass3, 1);
        chk("t6_err",     err3,  0);
        chk("t6_vec_end", vec3,  7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
